// File: rtl/cpu_trace_buffer.sv
// Instruction-trace FIFO: records committed instructions {[ts], pc, ir, branch, jump, zero}.
// Define CPU_TRACE_TS_EN to prepend a free-running TS_W-bit cycle timestamp to each entry.
module cpu_trace_buffer #(
    parameter int PC_W  = 32,
    parameter int IR_W  = 32,
    parameter int DEPTH = 16,
    parameter int MODE  = 0,
    parameter int TS_W  = 16,
`ifdef CPU_TRACE_TS_EN
    localparam bit TS_ON = 1'b1,
`else
    localparam bit TS_ON = 1'b0,
`endif
    localparam int TS_BITS = TS_ON ? TS_W : 0,
    localparam int ENTRY_W = PC_W + IR_W + 3 + TS_BITS,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               commit,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [IR_W-1:0]    ir_in,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    input  logic               enable,
    input  logic               clear,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [LVL_W-1:0]   level,
    output logic               overflow,
    output logic [7:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic [ENTRY_W-1:0] entry_in;

    logic flush;
    logic eligible;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign flush    = reset | clear;
    assign eligible = commit && enable && ((MODE == 0) || branch || jump);
    assign full     = (level_q == FULL_LVL);
    assign rd_valid = (level_q != '0);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = eligible && (!full || pop);
    assign drop     = eligible && full && !pop;

`ifdef CPU_TRACE_TS_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = ts_q + TS_W'(1);

    always_ff @(posedge clk) begin
        if (flush) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign entry_in = {ts_q, pc_in, ir_in, branch, jump, zero};
`else
    assign entry_in = {pc_in, ir_in, branch, jump, zero};
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately not reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: two instances (capture-all and control-flow-only) on shared
// inputs, compared against queue-based reference models of the trace FIFO.
`timescale 1ns/1ps
module tb_cpu_trace_buffer;

    localparam int PC_W  = 32;
    localparam int IR_W  = 32;
    localparam int DEPTH = 16;
    localparam int TS_W  = 4;
`ifdef CPU_TRACE_TS_EN
    localparam int TSB = TS_W;
`else
    localparam int TSB = 0;
`endif
    localparam int EW = PC_W + IR_W + 3 + TSB;
    localparam int LW = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            commit = 1'b0;
    logic [PC_W-1:0] pc_in = '0;
    logic [IR_W-1:0] ir_in = '0;
    logic            branch = 1'b0;
    logic            jump = 1'b0;
    logic            zero = 1'b0;
    logic            enable = 1'b1;
    logic            clear = 1'b0;
    logic            rd_ready = 1'b0;

    logic            rd_valid_a, rd_valid_b;
    logic [EW-1:0]   rd_data_a, rd_data_b;
    logic [LW-1:0]   level_a, level_b;
    logic            overflow_a, overflow_b;
    logic [7:0]      drop_cnt_a, drop_cnt_b;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per instance plus status and a cycle counter.
    logic [EW-1:0] exp_q_a[$];
    logic [EW-1:0] exp_q_b[$];
    bit            ovf_a = 0, ovf_b = 0;
    int            dc_a = 0, dc_b = 0;
    int            ts_m = 0;

    cpu_trace_buffer #(.PC_W(PC_W), .IR_W(IR_W), .DEPTH(DEPTH), .MODE(0), .TS_W(TS_W)) dut_a (
        .clk(clk), .reset(reset), .commit(commit), .pc_in(pc_in), .ir_in(ir_in),
        .branch(branch), .jump(jump), .zero(zero), .enable(enable), .clear(clear),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a),
        .level(level_a), .overflow(overflow_a), .drop_cnt(drop_cnt_a)
    );

    cpu_trace_buffer #(.PC_W(PC_W), .IR_W(IR_W), .DEPTH(DEPTH), .MODE(1), .TS_W(TS_W)) dut_b (
        .clk(clk), .reset(reset), .commit(commit), .pc_in(pc_in), .ir_in(ir_in),
        .branch(branch), .jump(jump), .zero(zero), .enable(enable), .clear(clear),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b),
        .level(level_b), .overflow(overflow_b), .drop_cnt(drop_cnt_b)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] make_entry();
`ifdef CPU_TRACE_TS_EN
        return {TS_W'(ts_m), pc_in, ir_in, branch, jump, zero};
`else
        return {pc_in, ir_in, branch, jump, zero};
`endif
    endfunction

    function automatic logic [PC_W-1:0] pc_of(input logic [EW-1:0] d);
        return d[IR_W+3 +: PC_W];
    endfunction

    always @(posedge clk) begin
        logic [EW-1:0] e;
        bit was_full_a, was_full_b, pop_a, pop_b;
        e = make_entry();
        if (reset || clear) begin
            exp_q_a.delete();
            exp_q_b.delete();
            ovf_a = 0; ovf_b = 0; dc_a = 0; dc_b = 0; ts_m = 0;
        end else begin
            was_full_a = (exp_q_a.size() == DEPTH);
            was_full_b = (exp_q_b.size() == DEPTH);
            pop_a = rd_ready && (exp_q_a.size() != 0);
            pop_b = rd_ready && (exp_q_b.size() != 0);
            if (pop_a) void'(exp_q_a.pop_front());
            if (pop_b) void'(exp_q_b.pop_front());
            if (commit && enable) begin
                if (!was_full_a || pop_a) exp_q_a.push_back(e);
                else begin ovf_a = 1; if (dc_a < 255) dc_a++; end
                if (branch || jump) begin
                    if (!was_full_b || pop_b) exp_q_b.push_back(e);
                    else begin ovf_b = 1; if (dc_b < 255) dc_b++; end
                end
            end
            ts_m = (ts_m + 1) % (1 << TS_W);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        commit = 0; branch = 0; jump = 0; zero = 0; clear = 0; reset = 0; rd_ready = 0;
    endtask

    task automatic do_clear();
        clear = 1; tick(); clear = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (10) tick();
        reset = 0;
        checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rd_valid_a); end
        checks++; if (rd_data_a !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", rd_data_a); end
        checks++; if (level_a !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level_a); end
        checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow_a); end
        checks++; if (drop_cnt_a !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt_a); end
        checks++; if (rd_valid_b !== 1'b0 || level_b !== '0) begin errors++; $display("FAIL reset_b got v=%0b l=%0d exp 0", rd_valid_b, level_b); end
    endtask

    task automatic test_in_order();
        idle();
        enable = 1;
        for (int i = 0; i < 4; i++) begin
            commit = 1; pc_in = PC_W'(i * 4); ir_in = $urandom(); zero = 1'($urandom_range(0, 1));
            tick();
        end
        commit = 0;
        checks++; if (level_a !== LW'(4)) begin errors++; $display("FAIL order_level got %0d exp 4", level_a); end
        checks++; if (rd_valid_a !== 1'b1) begin errors++; $display("FAIL order_valid got %0b exp 1", rd_valid_a); end
        checks++; if (pc_of(rd_data_a) !== 32'h0) begin errors++; $display("FAIL order_head got %h exp 0", pc_of(rd_data_a)); end
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_of(rd_data_a) !== PC_W'(i * 4)) begin errors++; $display("FAIL order_drain%0d got %h exp %h", i, pc_of(rd_data_a), i * 4); end
            tick();
        end
        rd_ready = 0;
        checks++; if (level_a !== '0 || rd_valid_a !== 1'b0) begin errors++; $display("FAIL order_empty got l=%0d v=%0b exp 0", level_a, rd_valid_a); end
    endtask

    task automatic test_mode_filter();
        idle();
        do_clear();
        for (int i = 0; i < 6; i++) begin
            commit = 1; pc_in = PC_W'(32'h100 + i * 4); ir_in = $urandom();
            branch = (i == 1); jump = (i == 4); zero = 1'($urandom_range(0, 1));
            tick();
        end
        idle();
        checks++; if (level_b !== LW'(2)) begin errors++; $display("FAIL filter_level got %0d exp 2", level_b); end
        checks++; if (level_a !== LW'(6)) begin errors++; $display("FAIL filter_all_level got %0d exp 6", level_a); end
        checks++; if (rd_data_b[2:1] !== 2'b10 || pc_of(rd_data_b) !== 32'h104) begin errors++; $display("FAIL filter_first got bj=%b pc=%h exp 10 104", rd_data_b[2:1], pc_of(rd_data_b)); end
        rd_ready = 1; tick(); rd_ready = 0;
        checks++; if (rd_data_b[2:1] !== 2'b01 || pc_of(rd_data_b) !== 32'h110) begin errors++; $display("FAIL filter_second got bj=%b pc=%h exp 01 110", rd_data_b[2:1], pc_of(rd_data_b)); end
    endtask

    task automatic test_overflow();
        idle();
        do_clear();
        for (int i = 0; i < 20; i++) begin
            commit = 1; pc_in = PC_W'(i * 4); ir_in = $urandom(); tick();
        end
        commit = 0;
        checks++; if (level_a !== LW'(16)) begin errors++; $display("FAIL ovf_level got %0d exp 16", level_a); end
        checks++; if (overflow_a !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow_a); end
        checks++; if (drop_cnt_a !== 8'd4) begin errors++; $display("FAIL ovf_drop got %0d exp 4", drop_cnt_a); end
        checks++; if (pc_of(rd_data_a) !== 32'h0) begin errors++; $display("FAIL ovf_head got %h exp 0", pc_of(rd_data_a)); end
    endtask

    task automatic test_back_to_back();
        // FIFO is full from test_overflow; push and pop together.
        commit = 1; pc_in = 32'h1000; ir_in = $urandom(); rd_ready = 1;
        tick();
        commit = 0; rd_ready = 0;
        checks++; if (level_a !== LW'(16)) begin errors++; $display("FAIL b2b_level got %0d exp 16", level_a); end
        checks++; if (drop_cnt_a !== 8'd4) begin errors++; $display("FAIL b2b_drop got %0d exp 4", drop_cnt_a); end
        rd_ready = 1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (pc_of(rd_data_a) !== ((i < 15) ? PC_W'((i + 1) * 4) : 32'h1000)) begin
                errors++; $display("FAIL b2b_drain%0d got %h", i, pc_of(rd_data_a));
            end
            checks++;
            if (rd_data_a !== exp_q_a[0]) begin errors++; $display("FAIL b2b_entry%0d got %h exp %h", i, rd_data_a, exp_q_a[0]); end
            tick();
        end
        rd_ready = 0;
        checks++; if (rd_valid_a !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", rd_valid_a); end
    endtask

    task automatic test_saturate();
        idle();
        do_clear();
        commit = 1;
        for (int i = 0; i < 316; i++) begin
            pc_in = $urandom(); ir_in = $urandom(); tick();
        end
        checks++; if (drop_cnt_a !== 8'd255) begin errors++; $display("FAIL sat_drop got %0d exp 255", drop_cnt_a); end
        checks++; if (level_a !== LW'(16) || overflow_a !== 1'b1) begin errors++; $display("FAIL sat_state got l=%0d o=%0b exp 16 1", level_a, overflow_a); end
        clear = 1; rd_ready = 1;
        tick();
        idle();
        checks++; if (level_a !== '0 || overflow_a !== 1'b0 || drop_cnt_a !== 8'd0) begin
            errors++; $display("FAIL clear_state got l=%0d o=%0b d=%0d exp 0 0 0", level_a, overflow_a, drop_cnt_a);
        end
        tick();
        checks++; if (rd_valid_a !== 1'b0 || level_a !== '0) begin errors++; $display("FAIL clear_nostore got v=%0b l=%0d exp 0 0", rd_valid_a, level_a); end
    endtask

    task automatic test_mid_reset();
        idle();
        for (int i = 0; i < 5; i++) begin
            commit = 1; branch = 1; pc_in = $urandom(); tick();
        end
        reset = 1; rd_ready = 1;
        tick();
        idle();
        checks++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || rd_data_a !== '0) begin
            errors++; $display("FAIL midreset got va=%0b vb=%0b d=%h exp 0", rd_valid_a, rd_valid_b, rd_data_a);
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] ea, eb;
        idle();
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            commit   = ($urandom_range(0, 99) < 60);
            enable   = ($urandom_range(0, 99) < 90);
            branch   = ($urandom_range(0, 3) == 0);
            jump     = ($urandom_range(0, 5) == 0);
            zero     = 1'($urandom_range(0, 1));
            pc_in    = $urandom();
            ir_in    = $urandom();
            rd_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 80);
            clear    = ($urandom_range(0, 399) == 0);
            tick();
            ea = (exp_q_a.size() != 0) ? exp_q_a[0] : '0;
            eb = (exp_q_b.size() != 0) ? exp_q_b[0] : '0;
            checks++;
            if (rd_valid_a !== (exp_q_a.size() != 0) || rd_data_a !== ea || level_a !== LW'(exp_q_a.size())
                || overflow_a !== ovf_a || drop_cnt_a !== 8'(dc_a)) begin
                errors++;
                $display("FAIL rand_a c=%0d got v=%0b d=%h l=%0d o=%0b n=%0d exp v=%0b d=%h l=%0d o=%0b n=%0d", c,
                         rd_valid_a, rd_data_a, level_a, overflow_a, drop_cnt_a,
                         exp_q_a.size() != 0, ea, exp_q_a.size(), ovf_a, dc_a);
            end
            checks++;
            if (rd_valid_b !== (exp_q_b.size() != 0) || rd_data_b !== eb || level_b !== LW'(exp_q_b.size())
                || overflow_b !== ovf_b || drop_cnt_b !== 8'(dc_b)) begin
                errors++;
                $display("FAIL rand_b c=%0d got v=%0b d=%h l=%0d o=%0b n=%0d exp v=%0b d=%h l=%0d o=%0b n=%0d", c,
                         rd_valid_b, rd_data_b, level_b, overflow_b, drop_cnt_b,
                         exp_q_b.size() != 0, eb, exp_q_b.size(), ovf_b, dc_b);
            end
        end
        idle();
        enable = 1;
    endtask

`ifdef CPU_TRACE_TS_EN
    task automatic test_timestamp();
        idle();
        reset = 1; tick(); reset = 0;
        for (int c = 0; c <= 20; c++) begin
            commit = (c == 3 || c == 20); pc_in = PC_W'(c); tick();
        end
        idle();
        checks++; if (rd_data_a[EW-1 -: TS_W] !== TS_W'(3)) begin errors++; $display("FAIL ts_first got %0d exp 3", rd_data_a[EW-1 -: TS_W]); end
        rd_ready = 1; tick(); rd_ready = 0;
        checks++; if (rd_data_a[EW-1 -: TS_W] !== TS_W'(4)) begin errors++; $display("FAIL ts_wrap got %0d exp 4", rd_data_a[EW-1 -: TS_W]); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_in_order();
        test_mode_filter();
        test_overflow();
        test_back_to_back();
        test_saturate();
        test_mid_reset();
        test_random();
`ifdef CPU_TRACE_TS_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
